seg7_scan_display: RTL and testbench

- Multiplexed 8-digit seven-segment display controller fed by the CPU's memory-mapped display register; drives the board pins `atog[7:0]` and `seg_cs[7:0]` inside the top level.
- Accepts 32-bit writes into a shadow buffer and commits them at frame boundaries, so no digit ever shows a torn value.
- Scans the digits at a programmable rate, with optional leading-zero blanking.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_display.sv | 88 ++++++++
 tb/tb_seg7_scan_display.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display: active-low segment
// patterns, the blank pattern and the hex-to-segment decode function.
package seg7_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned SEG_W  = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_A     = 8'h88;
  localparam logic [SEG_W-1:0] SEG_B     = 8'h83;
  localparam logic [SEG_W-1:0] SEG_C     = 8'hC6;
  localparam logic [SEG_W-1:0] SEG_D     = 8'hA1;
  localparam logic [SEG_W-1:0] SEG_E     = 8'h86;
  localparam logic [SEG_W-1:0] SEG_F     = 8'h8E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Active-low segments, bit0=a .. bit6=g, bit7=dp held off.
  function automatic logic [SEG_W-1:0] hex_decode(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = hex_decode(nib);

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 8-digit seven-segment controller with frame-boundary commit
// of CPU writes and optional leading-zero blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              blank_lz,
  output logic [SEG_W-1:0]  atog,
  output logic [DIGITS-1:0] seg_cs,
  output logic              frame_sync
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  logic [DIV_W-1:0]  div,     div_nxt;
  logic [IDX_W-1:0]  idx,     idx_nxt;
  logic [DATA_W-1:0] shadow,  shadow_nxt;
  logic [DATA_W-1:0] disp,    disp_nxt;
  logic              pending, pending_nxt;

  logic              tick;
  logic              boundary;
  logic              commit;
  logic              blank;
  logic [3:0]        nib_nxt;
  logic [SEG_W-1:0]  seg_nxt_c;
  logic [SEG_W-1:0]  atog_nxt;
  logic [DIGITS-1:0] seg_cs_nxt;

  // Next-state: divider, scan index, write buffer and frame commit.
  always_comb begin
    tick        = (div == DIV_W'(CLK_DIV - 1));
    div_nxt     = tick ? '0 : div + DIV_W'(1);
    idx_nxt     = tick ? idx + IDX_W'(1) : idx;
    boundary    = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    commit      = boundary && pending;
    disp_nxt    = commit ? shadow : disp;
    shadow_nxt  = wr_en ? wr_data : shadow;
    pending_nxt = pending;
    if (commit) pending_nxt = 1'b0;
    if (wr_en)  pending_nxt = 1'b1;
  end

  // Outputs are derived from next-state so they move on the same edge as idx.
  always_comb begin
    nib_nxt    = disp_nxt[{idx_nxt, 2'b00} +: 4];
    blank      = blank_lz && (idx_nxt != '0) &&
                 ((disp_nxt >> {idx_nxt, 2'b00}) == '0);
    atog_nxt   = blank ? SEG_BLANK : seg_nxt_c;
    seg_cs_nxt = ~(DIGITS'(1) << idx_nxt);
  end

  seg7_hex_decode u_hex_decode (
    .nib   (nib_nxt),
    .seg_c (seg_nxt_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div        <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      seg_cs     <= ~DIGITS'(1);
      atog       <= SEG_0;
      frame_sync <= 1'b0;
    end else begin
      div        <= div_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      disp       <= disp_nxt;
      pending    <= pending_nxt;
      seg_cs     <= seg_cs_nxt;
      atog       <= atog_nxt;
      frame_sync <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed self-checking bench for seg7_scan_display with CLK_DIV=2.
module tb_seg7_scan_display;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        blank_lz;
  logic [7:0]  atog;
  logic [7:0]  seg_cs;
  logic        frame_sync;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_display #(.CLK_DIV(2), .NUM_DIGITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .blank_lz   (blank_lz),
    .atog       (atog),
    .seg_cs     (seg_cs),
    .frame_sync (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock; inputs set before the call are captured on the posedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_atog(input logic [31:0] val, input logic blz, input int d);
    logic [31:0] upper;
    logic [3:0]  nib;
    upper = val >> (4 * d);
    nib   = val[4*d +: 4];
    if (blz && d != 0 && upper == 32'h0) return 8'hFF;
    return seg_tbl[nib];
  endfunction

  // Sample the current digit against the expected display value, then clock.
  task automatic check_cycle(input logic [31:0] val, input logic blz);
    int          d;
    logic [7:0]  cs;
    d  = (cyc / 2) % 8;
    cs = ~(8'h01 << d);
    check("seg_cs", seg_cs, cs);
    check("atog", atog, exp_atog(val, blz, d));
    check("frame_sync", {7'h0, frame_sync}, {7'h0, (cyc > 0 && cyc % 16 == 0)});
    step();
  endtask

  task automatic run_until_frame(input logic [31:0] val, input logic blz);
    while (cyc % 16 != 0) check_cycle(val, blz);
  endtask

  task automatic run_frame(input logic [31:0] val, input logic blz);
    repeat (16) check_cycle(val, blz);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_seg_cs", seg_cs, 8'hFE);
    check("rst_atog", atog, 8'hC0);
    check("rst_frame_sync", {7'h0, frame_sync}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 32'h0;
    blank_lz = 1'b0;
    @(negedge clk);
    do_reset();

    // Free-running scan after reset: all zeros, frame_sync at cycle 16.
    run_frame(32'h0, 1'b0);

    // Mid-frame write stays invisible until the wrap.
    repeat (5) check_cycle(32'h0, 1'b0);
    wr_en = 1'b1; wr_data = 32'h12345678;
    check_cycle(32'h0, 1'b0);
    wr_en = 1'b0;
    run_until_frame(32'h0, 1'b0);
    run_frame(32'h12345678, 1'b0);

    // Two writes before the boundary: the last one wins.
    repeat (2) check_cycle(32'h12345678, 1'b0);
    wr_en = 1'b1; wr_data = 32'hAAAAAAAA;
    check_cycle(32'h12345678, 1'b0);
    wr_data = 32'h0000BEEF;
    check_cycle(32'h12345678, 1'b0);
    wr_en = 1'b0;
    run_until_frame(32'h12345678, 1'b0);
    run_frame(32'h0000BEEF, 1'b0);

    // Write in the same cycle as the committing wrap edge.
    repeat (3) check_cycle(32'h0000BEEF, 1'b0);
    wr_en = 1'b1; wr_data = 32'h11111111;
    check_cycle(32'h0000BEEF, 1'b0);
    wr_en = 1'b0;
    while (cyc % 16 != 15) check_cycle(32'h0000BEEF, 1'b0);
    wr_en = 1'b1; wr_data = 32'h22222222;
    check_cycle(32'h0000BEEF, 1'b0);
    wr_en = 1'b0;
    run_frame(32'h11111111, 1'b0);
    run_frame(32'h22222222, 1'b0);

    // Leading-zero blanking on and then off.
    repeat (4) check_cycle(32'h22222222, 1'b0);
    wr_en = 1'b1; wr_data = 32'h000000A5;
    check_cycle(32'h22222222, 1'b0);
    wr_en = 1'b0;
    blank_lz = 1'b1;
    run_until_frame(32'h22222222, 1'b1);
    run_frame(32'h000000A5, 1'b1);
    blank_lz = 1'b0;
    run_frame(32'h000000A5, 1'b0);

    // Reset at digit 5 with a write pending: the write is dropped.
    repeat (2) check_cycle(32'h000000A5, 1'b0);
    wr_en = 1'b1; wr_data = 32'hDEADBEEF;
    check_cycle(32'h000000A5, 1'b0);
    wr_en = 1'b0;
    while (cyc % 16 != 10) check_cycle(32'h000000A5, 1'b0);
    do_reset();
    run_frame(32'h0, 1'b0);
    run_frame(32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
